// File: rtl/noc_pkg.sv
// Shared NoC payload layout and statistics widths for traffic generators and checkers.
package noc_pkg;

    localparam int unsigned SRC_LSB     = 0;
    localparam int unsigned SRC_W       = 16;
    localparam int unsigned SEQ_LSB     = 16;
    localparam int unsigned SEQ_W       = 32;
    localparam int unsigned TS_LSB      = 48;
    localparam int unsigned TS_W        = 32;
    localparam int unsigned PAYLOAD_MIN = 80;

    localparam int unsigned RX_CNT_W    = 32;
    localparam int unsigned ERR_CNT_W   = 16;
    localparam int unsigned LAT_W       = 32;
    localparam int unsigned LAT_SUM_W   = 48;

    // Header fields at the bottom of the payload, src in the LSBs.
    typedef struct packed {
        logic [TS_W-1:0]  ts;
        logic [SEQ_W-1:0] seq;
        logic [SRC_W-1:0] src;
    } flit_hdr_t;

    function automatic logic [ERR_CNT_W-1:0] err_inc(input logic [ERR_CNT_W-1:0] c);
        return (c == '1) ? c : c + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/pe_traffic_checker_seq_tracker.sv
// Per-source expected-sequence table with registered lookup and same-source write bypass.
module seq_tracker
    import noc_pkg::*;
#(
    parameter int unsigned NSRC = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [SRC_W-1:0] lk_src,
    input  logic             s1_valid,
    input  logic             s1_addr_ok,
    input  logic [SRC_W-1:0] s1_src,
    input  logic [SEQ_W-1:0] s1_seq,
    output logic             seq_valid,
    output logic             seq_ok
);

    localparam int unsigned IDX_W = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic [SEQ_W-1:0] seq_tbl [NSRC];
    logic [SEQ_W-1:0] exp_q;
    logic [SEQ_W-1:0] wr_data;
    logic [SEQ_W-1:0] lk_data;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] lk_idx;
    logic             wr_en;
    logic             lk_in_range;
    logic             lk_hit;

    assign wr_en       = s1_valid && s1_addr_ok;
    assign wr_idx      = IDX_W'(s1_src);
    assign wr_data     = s1_seq + SEQ_W'(1);
    assign lk_idx      = IDX_W'(lk_src);
    assign lk_in_range = (lk_src < SRC_W'(NSRC));
    assign lk_data     = lk_in_range ? seq_tbl[lk_idx] : '0;
    // The entry being written this cycle is not yet in the table; forward it.
    assign lk_hit      = wr_en && (s1_src == lk_src);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < int'(NSRC); i++) begin
                seq_tbl[i] <= '0;
            end
            exp_q <= '0;
        end else begin
            if (wr_en) begin
                seq_tbl[wr_idx] <= wr_data;
            end
            exp_q <= lk_hit ? wr_data : lk_data;
        end
    end

    assign seq_valid = s1_valid && s1_addr_ok;
    assign seq_ok    = seq_valid && (s1_seq == exp_q);

endmodule

// File: rtl/pe_traffic_checker.sv
// Receive-side NoC endpoint: checks destination and per-source ordering, gathers latency stats.
module pe_traffic_checker
    import noc_pkg::*;
#(
    parameter int X          = 3,
    parameter int Y          = 5,
    parameter int x_size     = $clog2(X),
    parameter int y_size     = $clog2(Y),
    parameter int data_width = 256,
    parameter int MY_X       = 0,
    parameter int MY_Y       = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               w_valid_pe,
    input  logic [x_size+y_size+data_width-1:0] w_data_pe,
    input  logic [31:0]                        cycle_now,
    input  logic                               clear,
    input  logic [31:0]                        expect_count,
    output logic [RX_CNT_W-1:0]                receive_count,
    output logic [ERR_CNT_W-1:0]               addr_err_count,
    output logic [ERR_CNT_W-1:0]               seq_err_count,
    output logic [LAT_SUM_W-1:0]               lat_sum,
    output logic [LAT_W-1:0]                   lat_max,
    output logic                               done,
    output logic                               err
);

    localparam int unsigned NSRC = X * Y;
    localparam int unsigned PB   = x_size + y_size;

    flit_hdr_t         hdr_in;
    logic [x_size-1:0] dest_x;
    logic [y_size-1:0] dest_y;
    logic              addr_ok;

    assign dest_x  = w_data_pe[x_size-1:0];
    assign dest_y  = w_data_pe[PB-1:x_size];
    assign hdr_in  = w_data_pe[PB +: PAYLOAD_MIN];
    assign addr_ok = (dest_x == x_size'(MY_X)) && (dest_y == y_size'(MY_Y))
                     && (hdr_in.src < SRC_W'(NSRC));

    if (data_width > int'(PAYLOAD_MIN)) begin : g_pad
        logic unused_payload;
        assign unused_payload = ^w_data_pe[PB+data_width-1:PB+PAYLOAD_MIN];
    end

    // S1: capture the arrival and its latency against the shared timebase.
    logic             s1_valid;
    logic             s1_addr_ok;
    logic [SRC_W-1:0] s1_src;
    logic [SEQ_W-1:0] s1_seq;
    logic [LAT_W-1:0] s1_lat;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            s1_valid   <= 1'b0;
            s1_addr_ok <= 1'b0;
            s1_src     <= '0;
            s1_seq     <= '0;
            s1_lat     <= '0;
        end else begin
            s1_valid   <= w_valid_pe;
            s1_addr_ok <= addr_ok;
            s1_src     <= hdr_in.src;
            s1_seq     <= hdr_in.seq;
            s1_lat     <= cycle_now - hdr_in.ts;
        end
    end

    logic chk_valid;
    logic chk_ok;

    seq_tracker #(
        .NSRC (NSRC)
    ) u_seq_tracker (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .lk_src     (hdr_in.src),
        .s1_valid   (s1_valid),
        .s1_addr_ok (s1_addr_ok),
        .s1_src     (s1_src),
        .s1_seq     (s1_seq),
        .seq_valid  (chk_valid),
        .seq_ok     (chk_ok)
    );

    // S2: statistics; latency counts for every flit, good or bad.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            receive_count  <= '0;
            addr_err_count <= '0;
            seq_err_count  <= '0;
            lat_sum        <= '0;
            lat_max        <= '0;
        end else if (s1_valid) begin
            if (receive_count != '1) begin
                receive_count <= receive_count + RX_CNT_W'(1);
            end
            if (!s1_addr_ok) begin
                addr_err_count <= err_inc(addr_err_count);
            end
            if (chk_valid && !chk_ok) begin
                seq_err_count <= err_inc(seq_err_count);
            end
            lat_sum <= lat_sum + LAT_SUM_W'(s1_lat);
            if (s1_lat > lat_max) begin
                lat_max <= s1_lat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            done <= 1'b0;
            err  <= 1'b0;
        end else begin
            done <= (expect_count != '0) && (receive_count >= expect_count);
            err  <= (addr_err_count != '0) || (seq_err_count != '0);
        end
    end

endmodule

// File: tb/tb_pe_traffic_checker.sv
// Directed bench for pe_traffic_checker at PE (1,2) of a 3x5 mesh.
module tb_pe_traffic_checker;

    localparam int XS = 2;
    localparam int YS = 3;
    localparam int DW = 256;
    localparam int FW = XS + YS + DW;

    logic          clk;
    logic          rst;
    logic          w_valid_pe;
    logic [FW-1:0] w_data_pe;
    logic [31:0]   cycle_now;
    logic          clear;
    logic [31:0]   expect_count;
    logic [31:0]   receive_count;
    logic [15:0]   addr_err_count;
    logic [15:0]   seq_err_count;
    logic [47:0]   lat_sum;
    logic [31:0]   lat_max;
    logic          done;
    logic          err;

    int pass_cnt = 0;
    int total_cnt = 0;

    pe_traffic_checker #(
        .X(3), .Y(5), .x_size(XS), .y_size(YS), .data_width(DW), .MY_X(1), .MY_Y(2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .w_valid_pe     (w_valid_pe),
        .w_data_pe      (w_data_pe),
        .cycle_now      (cycle_now),
        .clear          (clear),
        .expect_count   (expect_count),
        .receive_count  (receive_count),
        .addr_err_count (addr_err_count),
        .seq_err_count  (seq_err_count),
        .lat_sum        (lat_sum),
        .lat_max        (lat_max),
        .done           (done),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  dx;
        logic [2:0]  dy;
        logic [15:0] src;
        logic [31:0] seq;
        logic [31:0] ts;
        logic [31:0] now;
        logic [31:0] rx;
        logic [15:0] aerr;
        logic [15:0] serr;
        logic [47:0] lsum;
        logic [31:0] lmax;
    } vec_t;

    vec_t vecs [9];

    function automatic logic [FW-1:0] mk_flit(input logic [1:0] dx, input logic [2:0] dy,
                                              input logic [15:0] src, input logic [31:0] seq,
                                              input logic [31:0] ts);
        logic [FW-1:0] f;
        f = '0;
        f[1:0]   = dx;
        f[4:2]   = dy;
        f[5+:16] = src;
        f[21+:32] = seq;
        f[53+:32] = ts;
        return f;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] dx, input logic [2:0] dy, input logic [15:0] src,
                         input logic [31:0] seq, input logic [31:0] ts, input logic [31:0] now);
        w_valid_pe = 1'b1;
        w_data_pe  = mk_flit(dx, dy, src, seq, ts);
        cycle_now  = now;
    endtask

    task automatic idle;
        w_valid_pe = 1'b0;
        w_data_pe  = '0;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic chk_stats(input string tag, input logic [31:0] rx, input logic [15:0] a,
                             input logic [15:0] s, input logic [47:0] sum, input logic [31:0] mx);
        chk({tag, " receive_count"},  64'(receive_count),  64'(rx));
        chk({tag, " addr_err_count"}, 64'(addr_err_count), 64'(a));
        chk({tag, " seq_err_count"},  64'(seq_err_count),  64'(s));
        chk({tag, " lat_sum"},        64'(lat_sum),        64'(sum));
        chk({tag, " lat_max"},        64'(lat_max),        64'(mx));
    endtask

    task automatic pulse_clear;
        clear = 1'b1;
        tick;
        clear = 1'b0;
    endtask

    initial begin
        logic [31:0] t;
        rst = 1'b1; clear = 1'b0; expect_count = '0; cycle_now = '0;
        idle;

        //                 dx    dy    src     seq    ts             now            rx  aerr serr lat_sum              lat_max
        vecs[0] = '{2'd1, 3'd2, 16'd4,  32'd0, 32'd10,        32'd10,        32'd1, 16'd0, 16'd0, 48'd0,  32'd0};
        vecs[1] = '{2'd1, 3'd2, 16'd4,  32'd1, 32'd20,        32'd25,        32'd2, 16'd0, 16'd0, 48'd5,  32'd5};
        vecs[2] = '{2'd2, 3'd2, 16'd4,  32'd7, 32'd30,        32'd33,        32'd3, 16'd1, 16'd0, 48'd8,  32'd5};
        vecs[3] = '{2'd1, 3'd2, 16'd4,  32'd2, 32'd40,        32'd40,        32'd4, 16'd1, 16'd0, 48'd8,  32'd5};
        vecs[4] = '{2'd1, 3'd2, 16'd15, 32'd0, 32'd0,         32'd1,         32'd5, 16'd2, 16'd0, 48'd9,  32'd5};
        vecs[5] = '{2'd1, 3'd2, 16'd4,  32'd5, 32'd50,        32'd60,        32'd6, 16'd2, 16'd1, 48'd19, 32'd10};
        vecs[6] = '{2'd1, 3'd2, 16'd4,  32'd6, 32'hFFFF_FFFE, 32'd3,         32'd7, 16'd2, 16'd1, 48'd24, 32'd10};
        vecs[7] = '{2'd1, 3'd3, 16'd0,  32'd0, 32'd100,       32'd100,       32'd8, 16'd3, 16'd1, 48'd24, 32'd10};
        vecs[8] = '{2'd1, 3'd2, 16'd14, 32'd0, 32'd0,         32'hFFFF_FFFF, 32'd9, 16'd3, 16'd1,
                    48'h1_0000_0017, 32'hFFFF_FFFF};

        // Reset and idle
        repeat (3) tick;
        rst = 1'b0;
        repeat (10) tick;
        chk_stats("reset", 32'd0, 16'd0, 16'd0, 48'd0, 32'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset err",  64'(err),  64'd0);

        // Single-flit vectors, cumulative statistics
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].dx, vecs[i].dy, vecs[i].src, vecs[i].seq, vecs[i].ts, vecs[i].now);
            tick;
            idle;
            tick;
            chk_stats($sformatf("vec%0d", i), vecs[i].rx, vecs[i].aerr, vecs[i].serr,
                      vecs[i].lsum, vecs[i].lmax);
            tick;
            chk($sformatf("vec%0d err", i), 64'(err),
                64'((vecs[i].aerr != 0) || (vecs[i].serr != 0)));
            chk($sformatf("vec%0d done", i), 64'(done), 64'd0);
        end

        pulse_clear;
        chk_stats("after clear", 32'd0, 16'd0, 16'd0, 48'd0, 32'd0);
        tick;
        chk("after clear err", 64'(err), 64'd0);

        // In-order stream, done timing and expect_count raise
        expect_count = 32'd10;
        t = 32'd1000;
        for (int k = 0; k < 10; k++) begin
            drive(2'd1, 3'd2, 16'd4, 32'(k), t, t);
            tick;
            t = t + 32'd1;
        end
        idle;
        tick;
        chk_stats("stream", 32'd10, 16'd0, 16'd0, 48'd0, 32'd0);
        chk("stream done at N+2", 64'(done), 64'd0);
        tick;
        chk("stream done at N+3", 64'(done), 64'd1);
        chk("stream err", 64'(err), 64'd0);
        expect_count = 32'd11;
        tick;
        chk("done drops on raised expect", 64'(done), 64'd0);
        expect_count = 32'd0;

        // Sequence gap with back-to-back bypass
        pulse_clear;
        drive(2'd1, 3'd2, 16'd3, 32'd0, 32'd0, 32'd0); tick;
        drive(2'd1, 3'd2, 16'd3, 32'd1, 32'd0, 32'd0); tick;
        drive(2'd1, 3'd2, 16'd3, 32'd3, 32'd0, 32'd0); tick;
        drive(2'd1, 3'd2, 16'd3, 32'd4, 32'd0, 32'd0); tick;
        idle;
        tick;
        chk_stats("gap", 32'd4, 16'd0, 16'd1, 48'd0, 32'd0);
        drive(2'd1, 3'd2, 16'd3, 32'd5, 32'd0, 32'd0); tick;
        idle;
        tick;
        chk("gap resync seq_err", 64'(seq_err_count), 64'd1);
        chk("gap resync rx",      64'(receive_count), 64'd5);
        tick;
        chk("gap err", 64'(err), 64'd1);

        // Timestamp wrap
        pulse_clear;
        drive(2'd1, 3'd2, 16'd6, 32'd0, 32'hFFFF_FFFE, 32'd3); tick;
        drive(2'd1, 3'd2, 16'd6, 32'd1, 32'd100, 32'd120);     tick;
        idle;
        tick;
        chk_stats("wrap", 32'd2, 16'd0, 16'd0, 48'd25, 32'd20);

        // Clear mid-stream: in-flight flits and the clear-cycle flit are dropped
        pulse_clear;
        t = 32'd500;
        for (int k = 0; k < 5; k++) begin
            drive(2'd1, 3'd2, 16'd5, 32'(k), t - 32'd7, t);
            tick;
            t = t + 32'd1;
        end
        drive(2'd1, 3'd2, 16'd5, 32'd5, t - 32'd7, t);
        clear = 1'b1;
        tick;
        clear = 1'b0;
        t = t + 32'd1;
        chk("midclear rx at N+1", 64'(receive_count), 64'd0);
        chk("midclear lat_sum at N+1", 64'(lat_sum), 64'd0);
        for (int k = 0; k < 4; k++) begin
            drive(2'd1, 3'd2, 16'd5, 32'(k), t, t);
            tick;
            t = t + 32'd1;
        end
        idle;
        tick;
        chk_stats("midclear", 32'd4, 16'd0, 16'd0, 48'd0, 32'd0);
        tick;
        chk("midclear err", 64'(err), 64'd0);

        // Reset mid-stream behaves like clear
        drive(2'd1, 3'd2, 16'd5, 32'd4, t - 32'd2, t); tick;
        rst = 1'b1;
        drive(2'd1, 3'd2, 16'd5, 32'd5, t - 32'd2, t); tick;
        rst = 1'b0;
        idle;
        tick;
        tick;
        chk_stats("midreset", 32'd0, 16'd0, 16'd0, 48'd0, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
